// File: rtl/ntt_pkg.sv
// Shared constants and modular add/sub helpers for the q=257 NTT datapath.
// Pure definitions: no latency, no flow control.
package ntt_pkg;

  localparam int Q  = 257;
  localparam int W  = 17;
  localparam int AW = 3;
  localparam int N  = 2 ** AW;

  // Both operands are < Q, so one conditional subtract is enough.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    if (x < y) r = x + W'(Q) - y;
    else       r = x - y;
    return r;
  endfunction

endpackage

// File: rtl/mod_mul_q.sv
// Registered (b * w) mod Q: one cycle, result and valid update only when en_i is high.
// Holds its output while en_i is low, so it follows the enclosing pipeline stall.
module mod_mul_q
  import ntt_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] w_i,
  output logic         vld_o,
  output logic [W-1:0] t_o
);

  localparam logic [2*W-1:0] QP = (2*W)'(Q);

  logic [2*W-1:0] prod;
  logic [W-1:0]   t_d;
  logic [W-1:0]   t_q;
  logic           vld_q;

  always_comb begin
    prod = {{W{1'b0}}, b_i} * {{W{1'b0}}, w_i};
    t_d  = W'(prod % QP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      t_q   <= '0;
    end else if (en_i) begin
      vld_q <= vld_i;
      t_q   <= t_d;
    end
  end

  assign vld_o = vld_q;
  assign t_o   = t_q;

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// 3-stage Cooley-Tukey butterfly mod 257: capture, multiply/reduce, add/sub; 3-cycle latency.
// Single global stall (adv) freezes every stage when the output is held; in_ready = adv.
module ntt_butterfly_pipe
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [AW-1:0] in_tw_idx,
  output logic [AW-1:0] tw_addr,
  input  logic [W-1:0]  tw_value,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b
);

  logic         adv;
  logic         v1_q, v2, v3_q;
  logic [W-1:0] a1_q, b1_q, w1_q, w1_d;
  logic [W-1:0] a2_q, t2;
  logic [W-1:0] oa_q, ob_q;

  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;
  assign tw_addr  = in_valid ? in_tw_idx : '0;

  // The psi table may return unreduced powers, so fold them below Q on capture.
  assign w1_d = W'(32'(tw_value) % Q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      w1_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      a1_q <= in_a;
      b1_q <= in_b;
      w1_q <= w1_d;
    end
  end

  mod_mul_q u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .vld_i (v1_q),
    .b_i   (b1_q),
    .w_i   (w1_q),
    .vld_o (v2),
    .t_o   (t2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a2_q <= '0;
    end else if (adv) begin
      a2_q <= a1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      oa_q <= '0;
      ob_q <= '0;
    end else if (adv) begin
      v3_q <= v2;
      oa_q <= mod_add(a2_q, t2);
      ob_q <= mod_sub(a2_q, t2);
    end
  end

  assign out_valid = v3_q;
  assign out_a     = oa_q;
  assign out_b     = ob_q;

endmodule
